// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared trit encodings, opcodes, fetch FSM states and ALU-op decode.
// Imported by control and fetch so both decode ALU operations identically.
package fetch_unit_pkg;

    localparam int DEF_PC_TRITS    = 9;
    localparam int DEF_INSTR_TRITS = 18;
    localparam int DEF_OPCODE_SIZE = 4;

    // Balanced-ternary trit encoding, 2 bits per trit
    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b10;
    localparam logic [1:0] TRIT_BAD  = 2'b11;

    // Opcodes, most significant trit first
    localparam logic [2*DEF_OPCODE_SIZE-1:0] OP_NOP = 8'b00_00_00_00;
    localparam logic [2*DEF_OPCODE_SIZE-1:0] OP_MV  = 8'b00_00_00_01;
    localparam logic [2*DEF_OPCODE_SIZE-1:0] OP_ADD = 8'b00_00_01_00;
    localparam logic [2*DEF_OPCODE_SIZE-1:0] OP_SUB = 8'b00_00_01_01;
    localparam logic [2*DEF_OPCODE_SIZE-1:0] OP_NEG = 8'b00_00_01_10;
    localparam logic [2*DEF_OPCODE_SIZE-1:0] OP_MIN = 8'b00_00_10_00;
    localparam logic [2*DEF_OPCODE_SIZE-1:0] OP_MAX = 8'b00_00_10_01;
    localparam logic [2*DEF_OPCODE_SIZE-1:0] OP_LD  = 8'b00_01_00_00;
    localparam logic [2*DEF_OPCODE_SIZE-1:0] OP_ST  = 8'b00_01_00_01;
    localparam logic [2*DEF_OPCODE_SIZE-1:0] OP_JMP = 8'b00_01_01_00;
    localparam logic [2*DEF_OPCODE_SIZE-1:0] OP_HLT = 8'b00_10_00_00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_HALTED
    } fetch_state_t;

    function automatic logic is_alu_op(input logic [2*DEF_OPCODE_SIZE-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_NEG, OP_MIN, OP_MAX};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory read bus.
//   req   - read request, held until ready
//   addr  - read address (trit-encoded PC)
//   ready - read data valid this cycle
//   rdata - instruction word
// master = fetch unit, slave = instruction memory.
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int PC_TRITS    = DEF_PC_TRITS,
    parameter int INSTR_TRITS = DEF_INSTR_TRITS
);
    logic                     req;
    logic [2*PC_TRITS-1:0]    addr;
    logic                     ready;
    logic [2*INSTR_TRITS-1:0] rdata;

    modport master (output req, addr, input ready, rdata);
    modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_unit_ternary_incrementer.sv
// ternary_incrementer: adds +1 to a balanced-ternary value, 2 bits per trit.
//   a         - input value, trit 0 in bits [1:0]
//   sum       - a + 1, carry out of the top trit dropped
//   carry_out - carry out of the top trit
// Ripple from trit 0: 0+1=+1, -1+1=0, +1+1=-1 with carry. An invalid trit
// stays invalid and absorbs the carry.
module ternary_incrementer
    import fetch_unit_pkg::*;
#(
    parameter int TRITS = DEF_PC_TRITS
) (
    input  logic [2*TRITS-1:0] a,
    output logic [2*TRITS-1:0] sum,
    output logic               carry_out
);
    logic [TRITS:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < TRITS; i++) begin : g_trit
        logic [1:0] t;
        assign t = a[2*i +: 2];
        assign sum[2*i +: 2] = !carry[i]        ? t         :
                               t == TRIT_ZERO   ? TRIT_POS  :
                               t == TRIT_POS    ? TRIT_NEG  :
                               t == TRIT_NEG    ? TRIT_ZERO : TRIT_BAD;
        assign carry[i+1] = carry[i] && t == TRIT_POS;
    end

    assign carry_out = carry[TRITS];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: executes control strobes (fetch/next/reset/halt) against
// instruction memory, owning the trit-encoded PC and instruction register.
//   clock, reset          - rising-edge clock, async active-low reset
//   do_fetch              - level, held while control is in FETCH
//   do_next               - one-cycle PC advance (IDLE only)
//   do_reset              - synchronous soft reset, beats every other strobe
//   do_halt               - level; freezes PC/IR until a reset
//   branch_taken/_target  - sampled with do_next
//   imem                  - instruction memory read bus (master side)
//   instr, opcode         - IR and its opcode field
//   is_alu_operation      - opcode decodes to an ALU op
//   pc                    - current PC
//   fetch_busy            - fetch in progress; control stalls execute on it
//   fault                 - sticky: a fetched word held an invalid trit
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                      PC_TRITS    = DEF_PC_TRITS,
    parameter int                      INSTR_TRITS = DEF_INSTR_TRITS,
    parameter int                      OPCODE_SIZE = DEF_OPCODE_SIZE,
    parameter logic [2*PC_TRITS-1:0]   RESET_PC    = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       do_fetch,
    input  logic                       do_next,
    input  logic                       do_reset,
    input  logic                       do_halt,
    input  logic                       branch_taken,
    input  logic [2*PC_TRITS-1:0]      branch_target,
    fetch_unit_if.master               imem,
    output logic [2*INSTR_TRITS-1:0]   instr,
    output logic [2*OPCODE_SIZE-1:0]   opcode,
    output logic                       is_alu_operation,
    output logic [2*PC_TRITS-1:0]      pc,
    output logic                       fetch_busy,
    output logic                       fault
);
    fetch_state_t            state;
    logic                    req_q;
    logic [2*PC_TRITS-1:0]   pc_inc;
    logic                    pc_carry_unused;
    logic                    word_bad;

    ternary_incrementer #(.TRITS(PC_TRITS)) u_inc (
        .a         (pc),
        .sum       (pc_inc),
        .carry_out (pc_carry_unused)
    );

    always_comb begin
        word_bad = 1'b0;
        for (int i = 0; i < INSTR_TRITS; i++)
            word_bad = word_bad | (imem.rdata[2*i +: 2] == TRIT_BAD);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            instr <= '0;
            fault <= 1'b0;
            req_q <= 1'b0;
        end else if (do_reset) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            instr <= '0;
            fault <= 1'b0;
            req_q <= 1'b0;
        end else if (do_halt) begin
            // Halt also wins over a same-cycle ready: the word is dropped
            state <= ST_HALTED;
            req_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // do_next outranks a simultaneous do_fetch
                    if (do_next) begin
                        pc <= branch_taken ? branch_target : pc_inc;
                    end else if (do_fetch) begin
                        state <= ST_REQ;
                        req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (imem.ready) begin
                        instr <= imem.rdata;
                        fault <= fault | word_bad;
                        state <= ST_DONE;
                        req_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (!do_fetch)
                        state <= ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign imem.req         = req_q;
    assign imem.addr        = pc;
    assign fetch_busy       = do_fetch && state != ST_DONE;
    assign opcode           = instr[2*INSTR_TRITS-1 -: 2*OPCODE_SIZE];
    assign is_alu_operation = is_alu_op(opcode);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [35:0] W_MV  = 36'h0194A16A5;
    localparam logic [35:0] W_ADD = 36'h040000001;
    localparam logic [35:0] W_BAD = 36'h040000003;
    localparam logic [35:0] W_SUB = 36'h050000002;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        do_fetch = 1'b0;
    logic        do_next = 1'b0;
    logic        do_reset = 1'b0;
    logic        do_halt = 1'b0;
    logic        branch_taken = 1'b0;
    logic [17:0] branch_target = '0;
    logic [35:0] instr;
    logic [7:0]  opcode;
    logic        is_alu_operation;
    logic [17:0] pc;
    logic        fetch_busy;
    logic        fault;
    int          checks = 0;
    int          errors = 0;

    fetch_unit_if imem ();

    fetch_unit dut (
        .clock            (clock),
        .reset            (reset),
        .do_fetch         (do_fetch),
        .do_next          (do_next),
        .do_reset         (do_reset),
        .do_halt          (do_halt),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem             (imem),
        .instr            (instr),
        .opcode           (opcode),
        .is_alu_operation (is_alu_operation),
        .pc               (pc),
        .fetch_busy       (fetch_busy),
        .fault            (fault)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic fetch_word(input logic [35:0] w);
        do_fetch = 1'b1;
        tick();
        imem.ready = 1'b1;
        imem.rdata = w;
        tick();
        imem.ready = 1'b0;
        do_fetch = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        #2;
        checks++; if (pc !== 18'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 18'h0); end
        checks++; if (instr !== 36'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem.req); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", fetch_busy); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_pc_increment;
        do_next = 1'b1;
        tick();
        checks++; if (pc !== 18'h00001) begin errors++; $display("FAIL pc_inc_0: got %h want %h", pc, 18'h00001); end
        tick();
        checks++; if (pc !== 18'h00006) begin errors++; $display("FAIL pc_inc_carry: got %h want %h", pc, 18'h00006); end
        branch_taken = 1'b1;
        branch_target = 18'h15555;
        tick();
        checks++; if (pc !== 18'h15555) begin errors++; $display("FAIL pc_branch_allpos: got %h want %h", pc, 18'h15555); end
        branch_taken = 1'b0;
        tick();
        checks++; if (pc !== 18'h2AAAA) begin errors++; $display("FAIL pc_wrap: got %h want %h", pc, 18'h2AAAA); end
        branch_taken = 1'b1;
        branch_target = 18'h00008;
        do_fetch = 1'b1;
        tick();
        checks++; if (pc !== 18'h00008) begin errors++; $display("FAIL pc_branch: got %h want %h", pc, 18'h00008); end
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL fetch_with_next_req: got %b want 0", imem.req); end
        do_next = 1'b0;
        do_fetch = 1'b0;
        branch_taken = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait;
        do_fetch = 1'b1;
        #1;
        checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL zw_busy_c0: got %b want 1", fetch_busy); end
        tick();
        checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL zw_req: got %b want 1", imem.req); end
        checks++; if (imem.addr !== 18'h00008) begin errors++; $display("FAIL zw_addr: got %h want %h", imem.addr, 18'h00008); end
        imem.ready = 1'b1;
        imem.rdata = W_MV;
        tick();
        imem.ready = 1'b0;
        checks++; if (instr !== W_MV) begin errors++; $display("FAIL zw_instr: got %h want %h", instr, W_MV); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL zw_busy_c2: got %b want 0", fetch_busy); end
        checks++; if (opcode !== OP_MV) begin errors++; $display("FAIL zw_opcode: got %h want %h", opcode, OP_MV); end
        checks++; if (is_alu_operation !== 1'b0) begin errors++; $display("FAIL zw_alu: got %b want 0", is_alu_operation); end
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL zw_req_done: got %b want 0", imem.req); end
        do_fetch = 1'b0;
        tick();
    endtask

    task automatic test_wait_states;
        do_fetch = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                imem.ready = 1'b1;
                imem.rdata = W_ADD;
            end else begin
                imem.rdata = W_BAD;
            end
            #1;
            checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL ws_req[%0d]: got %b want 1", c, imem.req); end
            checks++; if (imem.addr !== 18'h00008) begin errors++; $display("FAIL ws_addr[%0d]: got %h want %h", c, imem.addr, 18'h00008); end
            checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL ws_busy[%0d]: got %b want 1", c, fetch_busy); end
            tick();
        end
        imem.ready = 1'b0;
        checks++; if (instr !== W_ADD) begin errors++; $display("FAIL ws_instr: got %h want %h", instr, W_ADD); end
        checks++; if (is_alu_operation !== 1'b1) begin errors++; $display("FAIL ws_alu: got %b want 1", is_alu_operation); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ws_fault: got %b want 0", fault); end
        do_fetch = 1'b0;
        tick();
    endtask

    task automatic test_fault;
        fetch_word(W_BAD);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL flt_set: got %b want 1", fault); end
        checks++; if (instr !== W_BAD) begin errors++; $display("FAIL flt_instr: got %h want %h", instr, W_BAD); end
        fetch_word(W_SUB);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL flt_sticky: got %b want 1", fault); end
        checks++; if (instr !== W_SUB) begin errors++; $display("FAIL flt_instr2: got %h want %h", instr, W_SUB); end
        do_reset = 1'b1;
        tick();
        do_reset = 1'b0;
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL flt_clear: got %b want 0", fault); end
        checks++; if (pc !== 18'h0) begin errors++; $display("FAIL flt_soft_pc: got %h want 0", pc); end
        checks++; if (instr !== 36'h0) begin errors++; $display("FAIL flt_soft_instr: got %h want 0", instr); end
    endtask

    task automatic test_async_reset;
        fetch_word(W_BAD);
        do_next = 1'b1;
        branch_taken = 1'b1;
        branch_target = 18'h00001;
        tick();
        do_next = 1'b0;
        branch_taken = 1'b0;
        do_fetch = 1'b1;
        tick();
        checks++; if (imem.req !== 1'b1 || pc !== 18'h00001) begin errors++; $display("FAIL ar_pre: got req=%b pc=%h want req=1 pc=%h", imem.req, pc, 18'h00001); end
        reset = 1'b0;
        #1;
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL ar_req: got %b want 0", imem.req); end
        checks++; if (pc !== 18'h0) begin errors++; $display("FAIL ar_pc: got %h want 0", pc); end
        checks++; if (instr !== 36'h0) begin errors++; $display("FAIL ar_instr: got %h want 0", instr); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ar_fault: got %b want 0", fault); end
        do_fetch = 1'b0;
        imem.ready = 1'b1;
        imem.rdata = W_BAD;
        tick();
        reset = 1'b1;
        tick();
        imem.ready = 1'b0;
        checks++; if (instr !== 36'h0 || fault !== 1'b0 || imem.req !== 1'b0) begin errors++; $display("FAIL ar_late_ready: got instr=%h fault=%b req=%b want 0/0/0", instr, fault, imem.req); end
    endtask

    task automatic test_halt;
        fetch_word(W_SUB);
        do_next = 1'b1;
        tick();
        do_next = 1'b0;
        do_fetch = 1'b1;
        tick();
        checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL hlt_req_pre: got %b want 1", imem.req); end
        do_halt = 1'b1;
        imem.ready = 1'b1;
        imem.rdata = W_ADD;
        tick();
        checks++; if (instr !== W_SUB) begin errors++; $display("FAIL hlt_instr: got %h want %h", instr, W_SUB); end
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL hlt_req: got %b want 0", imem.req); end
        checks++; if (pc !== 18'h00001) begin errors++; $display("FAIL hlt_pc: got %h want %h", pc, 18'h00001); end
        do_halt = 1'b0;
        tick();
        tick();
        checks++; if (imem.req !== 1'b0 || instr !== W_SUB) begin errors++; $display("FAIL hlt_fetch_ignored: got req=%b instr=%h want 0/%h", imem.req, instr, W_SUB); end
        do_fetch = 1'b0;
        imem.ready = 1'b0;
        do_next = 1'b1;
        tick();
        do_next = 1'b0;
        checks++; if (pc !== 18'h00001) begin errors++; $display("FAIL hlt_next_ignored: got %h want %h", pc, 18'h00001); end
        do_reset = 1'b1;
        do_halt = 1'b1;
        tick();
        do_reset = 1'b0;
        do_halt = 1'b0;
        checks++; if (pc !== 18'h0 || instr !== 36'h0) begin errors++; $display("FAIL hlt_soft_reset: got pc=%h instr=%h want 0/0", pc, instr); end
        do_fetch = 1'b1;
        tick();
        checks++; if (imem.req !== 1'b1 || imem.addr !== 18'h0) begin errors++; $display("FAIL hlt_resume: got req=%b addr=%h want 1/0", imem.req, imem.addr); end
        do_fetch = 1'b0;
        do_reset = 1'b1;
        tick();
        do_reset = 1'b0;
    endtask

    initial begin
        imem.ready = 1'b0;
        imem.rdata = '0;
        test_reset();
        test_pc_increment();
        test_zero_wait();
        test_wait_states();
        test_fault();
        test_async_reset();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Responder side of the CPU control strobe interface: executes do_fetch / do_next / do_reset / do_halt against instruction memory and the program counter.
- Returns opcode and is_alu_operation to the control FSM.
- Sits between control, instruction memory and the decode/register stage.
- Owns the PC and instruction register (IR), both in 2-bit-per-trit balanced-ternary encoding: 00=0, 01=+1, 10=-1, 11=invalid.

Parameters:
PC_TRITS, 9, program counter / instruction memory address width in trits
INSTR_TRITS, 18, instruction word width in trits
OPCODE_SIZE, 4, opcode field width in trits; occupies the most significant trits of the IR
RESET_PC, all-zero trits, PC value after reset or do_reset

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
do_fetch  input  1  control strobe; level, held while control is in FETCH
do_next  input  1  control strobe; one cycle per instruction
do_reset  input  1  synchronous soft reset from control
do_halt  input  1  control halt indication; level
branch_taken  input  1  from datapath, sampled with do_next
branch_target  input  2*PC_TRITS  absolute target, sampled with do_next
imem_req  output  1  instruction memory read request
imem_addr  output  2*PC_TRITS  read address (equals pc)
imem_ready  input  1  read data valid this cycle
imem_rdata  input  2*INSTR_TRITS  instruction word
instr  output  2*INSTR_TRITS  current IR
opcode  output  2*OPCODE_SIZE  IR opcode field, to control
is_alu_operation  output  1  opcode decodes to an ALU op, to control
pc  output  2*PC_TRITS  current PC
fetch_busy  output  1  fetch in progress; integration gates control execute with !fetch_busy
fault  output  1  sticky: fetched word contains an invalid trit (11)

Behaviour:
- Reset (reset=0, asynchronous) and do_reset (synchronous, highest priority over all strobes) act identically:
  - state=IDLE; pc=RESET_PC; IR=0 (all trits zero); fault=0; imem_req=0.
  - A request in flight is abandoned; a late imem_ready is ignored.
- FSM states and transitions:
  - IDLE: do_fetch -> REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_ready: latch imem_rdata into IR, -> DONE.
  - DONE: on do_fetch=0 -> IDLE.
  - HALTED: entered from any state when do_halt=1. imem_req=0; pc and IR frozen; do_fetch and do_next ignored. Exit only by reset or do_reset.
- fetch_busy = do_fetch && state!=DONE (combinational).
- Minimum fetch: do_fetch seen at cycle 0; REQ at cycle 1; imem_ready at cycle 1 latches IR; DONE at cycle 2, fetch_busy=0; control advances at the end of cycle 2.
- Wait states: imem_ready may be held low any number of cycles. imem_req and imem_addr stay stable until imem_ready.
- do_next (state IDLE only; any other state: ignored and a $display warning is issued):
  - branch_taken=1: pc <= branch_target.
  - branch_taken=0: pc <= pc+1 in balanced ternary.
  - Increment is ripple from trit 0: +1+1 = -1 with carry; -1+1 = 0; 0+1 = +1.
  - Carry out of the top trit is dropped, so all-(+1) wraps to all-(-1).
- opcode = IR[2*INSTR_TRITS-1 -: 2*OPCODE_SIZE]; is_alu_operation = is_alu_op(opcode); both combinational from IR.
- fault: set on an IR latch whose data contains any 11 trit pair. The word is still latched and forwarded; control's invalid-opcode path handles it.
- Simultaneous events:
  - do_reset beats do_halt.
  - do_halt beats imem_ready: the word is not latched.
  - do_fetch and do_next together: do_next applied, do_fetch ignored that cycle (protocol violation, warning).

Decomposition:
- Shared parameters.vh: trit encodings (TRIT_ZERO/POS/NEG/BAD), opcode defines, fetch FSM state defines, and the is_alu_op function, so control and fetch decode ALU ops identically.
- Sub-module ternary_incrementer: parameterised by trit count; 2-bit-per-trit input; outputs sum and carry_out. Reusable for a future ternary PC adder.

Test Plan:
- Reset: reset=0 mid-REQ with pc=+1 -> imem_req=0, pc=all-zero, instr=0, fault=0 immediately, before the next edge.
- Zero-wait fetch: do_fetch, imem_ready in the REQ cycle with opcode=MV -> instr latched, fetch_busy low at cycle 2, opcode=MV, is_alu_operation=0.
- Wait states: imem_ready delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles, fetch_busy=1 throughout.
- PC increment: pc=0,+1 -> +1,-1 (carry); pc=all +1 -> all -1 (wrap); branch_taken=1 with target=-1,0 -> pc=-1,0.
- Fault: fetched word with one 11 trit -> fault=1 and remains set across later valid fetches until do_reset.
- Halt: do_halt during REQ, then imem_ready -> IR unchanged, imem_req=0; do_fetch ignored; do_reset -> IDLE, pc=RESET_PC.
